commit_stage_mp: RTL and testbench
==================================

// Module: commit_stage_mp
// PURPOSE
//  - N-port in-order retirement unit between the scoreboard head and the architectural state.
//  - Retires 0..NrCommitPorts entries per cycle and writes the GPR/FPR files.
//  - Commits stores to the LSU against a slot budget; accumulates fflags.
//  - Serialising ops (FENCE, FENCE.I, SFENCE.VMA, AMO, domain change) run through a registered FSM, port 0 only.
// PARAMETERS
//  - NrCommitPorts  default 2   retire width, 1..4.
//  - XLEN           default 64  result/CSR data width.
//  - VLEN           default 39  PC width.
// PORTS
//  - clk_i            in   1                   clock.
//  - rst_i            in   1                   reset, synchronous, active-high.
//  - halt_i           in   1                   block all retirement.
//  - single_step_i    in   1                   retire at most port 0.
//  - commit_instr_i   in   N x commit_entry_t  scoreboard head entries, in program order.
//  - commit_ack_o     out  N                   per-port retire; always a contiguous low-order mask.
//  - waddr_o          out  N x 5               destination register.
//  - wdata_o          out  N x XLEN            write data.
//  - we_gpr_o         out  N                   GPR write enable.
//  - we_fpr_o         out  N                   FPR write enable.
//  - lsu_free_i       in   $clog2(N+1)         free store-buffer slots this cycle.
//  - commit_lsu_o     out  N                   store commit, per port.
//  - no_st_pending_i  in   1                   store buffer empty.
//  - amo_resp_i       in   amo_resp_t          AMO ack/result.
//  - amo_valid_commit_o out 1                  AMO may execute.
//  - csr_op_o         out  fu_op               CSR operation.
//  - csr_wdata_o      out  XLEN                CSR write data.
//  - csr_rdata_i      in   XLEN                CSR read data.
//  - csr_exception_i  in   exception_t         CSR fault.
//  - commit_csr_o     out  1                   CSR commit.
//  - csr_write_fflags_o out 1                  fflags write.
//  - csr_write_dom_o  out  1                   curdom write.
//  - fence_o, fence_i_o, sfence_vma_o, flush_commit_o  out 1 each  one-cycle pulses.
//  - exception_o      out  exception_t         trap to controller.
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): FSM=IDLE, perf counters=0. All pulse outputs and acks 0 in that cycle.
//  - Port 0 retires when: valid, !ex.valid, !halt_i, and class is simple or store, or CSR with !csr_exception_i.valid.
//  - Port i>0 retires when:
//    - port i-1 retired, valid, !ex.valid, !single_step_i;
//    - class in {ALU, LOAD, CTRL_FLOW, MULT, FPU, STORE};
//    - no serialising class on any lower port; no CSR on any lower port.
//  - Stores: the k-th store in the retire window retires only if k <= lsu_free_i. The first store over budget cuts the mask at that port.
//  - we_fpr_o[i]=ack[i]&rd_fpr, else we_gpr_o[i]=ack[i]. CSR: wdata_o[0]=csr_rdata_i.
//  - fflags: csr_wdata_o = OR of ex.cause[4:0] over all acked FPU ports. csr_write_fflags_o is set if any FPU port is acked.
//  - FSM (state is registered; outputs decode from the registered state):
//    - IDLE: a serialising op valid at port 0 with no exception goes to DRAIN (AMO goes to AMO_WAIT). Domain change retires combinationally in IDLE.
//    - DRAIN: wait for no_st_pending_i=1, then go to ISSUE. halt_i=1 returns to IDLE with no pulse; the op is retried later.
//    - ISSUE: pulse fence_o, fence_i_o or sfence_vma_o, plus ack[0], for exactly 1 cycle, then IDLE.
//    - AMO_WAIT: amo_valid_commit_o=1 until amo_resp_i.ack. In the ack cycle: ack[0], we_gpr_o[0], wdata_o[0]=amo result, flush_commit_o, then IDLE.
//    - AMO_WAIT ignores halt_i because memory is already in flight.
//  - Latency: simple ops 0 cycles. FENCE-class ops take >=2 cycles, or DRAIN cycles + 1.
//  - Exceptions: exception_o = commit_instr_i[0].ex if valid, else csr_exception_i with tval=entry tval. Forced invalid under halt_i. An exception in port 0 blocks every ack.
// CONFIGURATION
//  - COMMIT_PERF_CNT_EN defined:
//    - adds outputs instret_o (64) = cumulative popcount(commit_ack_o);
//    - adds stall_cnt_o (32) = cycles with port 0 valid and not acked;
//    - both saturate and reset to 0.
//  - COMMIT_PERF_CNT_EN undefined: neither port nor counter exists.
// STRUCTURE
//  - commit_pkg holds:
//    - commit_entry_t {valid, pc, fu, op_class, ex, rd, rd_fpr, result, dom};
//    - op_class_e {SIMPLE, STORE, CSR, FENCE, FENCE_I, SFENCE, AMO, CHG_DOM};
//    - commit_state_e {IDLE, DRAIN, ISSUE, AMO_WAIT}.
//  - Sub-module commit_port_sel: computes the contiguous ack mask and store budget, combinational.
// TESTING
//  - N=2; ALU+ALU valid -> ack=2'b11, we_gpr_o=2'b11 same cycle.
//  - N=4; 3 stores, lsu_free_i=2 -> ack=4'b0011, commit_lsu_o=4'b0011.
//  - FENCE at port 0, no_st_pending_i low for 3 cycles -> fence_o pulse on the 5th cycle; ports 1+ never acked meanwhile.
//  - AMO with resp ack 4 cycles later, halt_i raised mid-way -> amo_valid_commit_o held 4 cycles; ack+flush_commit_o in the ack cycle.
//  - FPU cause 5'h01 on port 0 and 5'h04 on port 1 -> csr_wdata_o=5'h05, fflags write 1.
//  - rst_i asserted during DRAIN -> next cycle FSM=IDLE, all pulses 0, perf counters=0.

Source files
------------

// File: rtl/commit_pkg.sv
// rtl/commit_pkg.sv - types, widths and class helpers shared by the commit stage
package commit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 39;

  typedef enum logic [2:0] {
    FU_NONE, FU_ALU, FU_LOAD, FU_STORE, FU_CTRL_FLOW, FU_MULT, FU_FPU, FU_CSR
  } fu_e;

  typedef enum logic [2:0] {
    SIMPLE, STORE, CSR, FENCE, FENCE_I, SFENCE, AMO, CHG_DOM
  } op_class_e;

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, AMO_WAIT} commit_state_e;

  typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_FFLAGS, CSR_DOM} fu_op_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] result;
  } amo_resp_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    fu_e             fu;
    op_class_e       op_class;
    exception_t      ex;
    logic [4:0]      rd;
    logic            rd_fpr;
    logic [XLEN-1:0] result;
    logic [1:0]      dom;
  } commit_entry_t;

  // Units whose results may retire alongside an older instruction.
  function automatic logic is_multi_fu(fu_e fu);
    return fu inside {FU_ALU, FU_LOAD, FU_CTRL_FLOW, FU_MULT, FU_FPU, FU_STORE};
  endfunction

endpackage

// File: rtl/commit_port_sel.sv
// rtl/commit_port_sel.sv - contiguous retire mask with store-slot budget
module commit_port_sel
  import commit_pkg::*;
#(
  parameter  int unsigned NrCommitPorts = 2,
  localparam int unsigned CntW          = $clog2(NrCommitPorts + 1)
) (
  input  logic [NrCommitPorts-1:0] i_valid,
  input  logic [NrCommitPorts-1:0] i_ex_valid,
  input  op_class_e                i_op [NrCommitPorts],
  input  fu_e                      i_fu [NrCommitPorts],
  input  logic                     i_idle,
  input  logic                     i_halt,
  input  logic                     i_single_step,
  input  logic                     i_csr_ex,
  input  logic [CntW-1:0]          i_lsu_free,
  output logic [NrCommitPorts-1:0] o_ack
);

  logic [CntW-1:0] w_st_cnt;
  logic            w_take;
  logic            w_prev;
  logic            w_blk;
  logic            w_unused;

  assign w_unused = ^i_fu[0];

  always_comb begin
    o_ack    = '0;
    w_st_cnt = '0;
    w_take   = 1'b0;
    w_prev   = 1'b0;
    w_blk    = 1'b0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (i == 0) begin
        w_take = i_valid[0] && !i_ex_valid[0] && !i_halt && i_idle &&
                 ((i_op[0] inside {SIMPLE, STORE, CHG_DOM}) || (i_op[0] == CSR && !i_csr_ex));
      end else begin
        w_take = w_prev && !w_blk && i_valid[i] && !i_ex_valid[i] && !i_single_step &&
                 (i_op[i] inside {SIMPLE, STORE}) && is_multi_fu(i_fu[i]);
      end
      // The first store beyond the free slots breaks the chain here.
      if (w_take && i_op[i] == STORE) begin
        if (w_st_cnt < i_lsu_free) w_st_cnt = w_st_cnt + 1'b1;
        else                       w_take   = 1'b0;
      end
      o_ack[i] = w_take;
      w_prev   = w_take;
      w_blk    = w_blk || !(i_op[i] inside {SIMPLE, STORE});
    end
  end

endmodule

// File: rtl/commit_stage_mp.sv
// rtl/commit_stage_mp.sv - N-port in-order commit stage; COMMIT_PERF_CNT_EN adds instret/stall counters
module commit_stage_mp
  import commit_pkg::*;
#(
  parameter  int unsigned NrCommitPorts = 2,
  localparam int unsigned CntW          = $clog2(NrCommitPorts + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     halt_i,
  input  logic                     single_step_i,
  input  commit_entry_t            commit_instr_i [NrCommitPorts],
  output logic [NrCommitPorts-1:0] commit_ack_o,
  output logic [4:0]               waddr_o [NrCommitPorts],
  output logic [XLEN-1:0]          wdata_o [NrCommitPorts],
  output logic [NrCommitPorts-1:0] we_gpr_o,
  output logic [NrCommitPorts-1:0] we_fpr_o,
  input  logic [CntW-1:0]          lsu_free_i,
  output logic [NrCommitPorts-1:0] commit_lsu_o,
  input  logic                     no_st_pending_i,
  input  amo_resp_t                amo_resp_i,
  output logic                     amo_valid_commit_o,
  output fu_op_e                   csr_op_o,
  output logic [XLEN-1:0]          csr_wdata_o,
  input  logic [XLEN-1:0]          csr_rdata_i,
  input  exception_t               csr_exception_i,
  output logic                     commit_csr_o,
  output logic                     csr_write_fflags_o,
  output logic                     csr_write_dom_o,
  output logic                     fence_o,
  output logic                     fence_i_o,
  output logic                     sfence_vma_o,
  output logic                     flush_commit_o,
  output exception_t               exception_o
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]              instret_o,
  output logic [31:0]              stall_cnt_o
`endif
);

  commit_state_e            r_state;
  op_class_e                r_op;
  commit_entry_t            w_e0;
  logic                     w_idle;
  logic                     w_go;
  logic                     w_amo_done;
  logic [NrCommitPorts-1:0] w_sel_ack;
  logic [NrCommitPorts-1:0] w_valid;
  logic [NrCommitPorts-1:0] w_ex_valid;
  op_class_e                w_op [NrCommitPorts];
  fu_e                      w_fu [NrCommitPorts];
  logic [4:0]               w_fflags;
  logic                     w_unused;

  assign w_e0       = commit_instr_i[0];
  assign w_idle     = (r_state == IDLE) && !rst_i;
  assign w_go       = w_e0.valid && !w_e0.ex.valid && !halt_i;
  assign w_amo_done = (r_state == AMO_WAIT) && amo_resp_i.ack && !rst_i;

  always_comb begin
    w_unused = ^csr_exception_i.tval;
    for (int i = 0; i < NrCommitPorts; i++) begin
      w_valid[i]    = commit_instr_i[i].valid;
      w_ex_valid[i] = commit_instr_i[i].ex.valid;
      w_op[i]       = commit_instr_i[i].op_class;
      w_fu[i]       = commit_instr_i[i].fu;
      w_unused      = w_unused ^ (^commit_instr_i[i]);
    end
  end

  commit_port_sel #(.NrCommitPorts(NrCommitPorts)) u_port_sel (
    .i_valid       (w_valid),
    .i_ex_valid    (w_ex_valid),
    .i_op          (w_op),
    .i_fu          (w_fu),
    .i_idle        (w_idle),
    .i_halt        (halt_i),
    .i_single_step (single_step_i),
    .i_csr_ex      (csr_exception_i.valid),
    .i_lsu_free    (lsu_free_i),
    .o_ack         (w_sel_ack)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_op    <= SIMPLE;
    end else begin
      case (r_state)
        IDLE: if (w_go && (w_e0.op_class inside {FENCE, FENCE_I, SFENCE, AMO})) begin
          r_op    <= w_e0.op_class;
          r_state <= (w_e0.op_class == AMO) ? AMO_WAIT : DRAIN;
        end
        // Halt abandons the drain; the op re-enters from IDLE once released.
        DRAIN: if (halt_i) r_state <= IDLE;
               else if (no_st_pending_i) r_state <= ISSUE;
        ISSUE: r_state <= IDLE;
        AMO_WAIT: if (amo_resp_i.ack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fence_o            = !rst_i && (r_state == ISSUE) && (r_op == FENCE);
  assign fence_i_o          = !rst_i && (r_state == ISSUE) && (r_op == FENCE_I);
  assign sfence_vma_o       = !rst_i && (r_state == ISSUE) && (r_op == SFENCE);
  assign amo_valid_commit_o = !rst_i && (r_state == AMO_WAIT);
  assign flush_commit_o     = w_amo_done;

  always_comb begin
    commit_ack_o = w_sel_ack;
    if ((!rst_i && r_state == ISSUE && w_e0.valid) || w_amo_done) commit_ack_o[0] = 1'b1;
  end

  always_comb begin
    w_fflags           = '0;
    csr_write_fflags_o = 1'b0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      waddr_o[i]      = commit_instr_i[i].rd;
      wdata_o[i]      = commit_instr_i[i].result;
      we_fpr_o[i]     = commit_ack_o[i] && commit_instr_i[i].rd_fpr;
      we_gpr_o[i]     = commit_ack_o[i] && !commit_instr_i[i].rd_fpr;
      commit_lsu_o[i] = commit_ack_o[i] && (commit_instr_i[i].op_class == STORE);
      if (commit_ack_o[i] && commit_instr_i[i].fu == FU_FPU) begin
        w_fflags           = w_fflags | commit_instr_i[i].ex.cause[4:0];
        csr_write_fflags_o = 1'b1;
      end
    end
    if (w_amo_done) begin
      wdata_o[0]  = amo_resp_i.result;
      we_gpr_o[0] = 1'b1;
      we_fpr_o[0] = 1'b0;
    end else if (w_idle && w_e0.op_class == CSR) begin
      wdata_o[0] = csr_rdata_i;
    end
  end

  always_comb begin
    commit_csr_o    = commit_ack_o[0] && w_idle && (w_e0.op_class == CSR);
    csr_write_dom_o = commit_ack_o[0] && w_idle && (w_e0.op_class == CHG_DOM);
    csr_op_o        = CSR_NONE;
    csr_wdata_o     = XLEN'(w_fflags);
    if (w_idle && w_go && w_e0.op_class == CSR) begin
      csr_op_o    = CSR_RW;
      csr_wdata_o = w_e0.result;
    end else if (csr_write_dom_o) begin
      csr_op_o    = CSR_DOM;
      csr_wdata_o = XLEN'(w_e0.dom);
    end else if (csr_write_fflags_o) begin
      csr_op_o = CSR_FFLAGS;
    end
  end

  always_comb begin
    exception_o = '0;
    if (!halt_i) begin
      if (w_e0.valid && w_e0.ex.valid) begin
        exception_o = w_e0.ex;
      end else if (csr_exception_i.valid) begin
        exception_o      = csr_exception_i;
        exception_o.tval = w_e0.ex.tval;
      end
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic [63:0]     r_instret;
  logic [31:0]     r_stall;
  logic [CntW-1:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NrCommitPorts; i++) w_pop = w_pop + CntW'(commit_ack_o[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instret <= '0;
      r_stall   <= '0;
    end else begin
      if (r_instret > (64'hFFFF_FFFF_FFFF_FFFF - 64'(w_pop))) r_instret <= '1;
      else r_instret <= r_instret + 64'(w_pop);
      if (w_e0.valid && !commit_ack_o[0] && r_stall != '1) r_stall <= r_stall + 32'd1;
    end
  end

  assign instret_o   = r_instret;
  assign stall_cnt_o = r_stall;
`endif

endmodule

// File: tb/tb_commit_stage_mp.sv
// tb/tb_commit_stage_mp.sv - directed self-checking bench for commit_stage_mp (N=2 and N=4)
module tb_commit_stage_mp;
  import commit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, halt, sstep, no_st;
  amo_resp_t       amo_resp;
  logic [XLEN-1:0] csr_rdata;
  exception_t      csr_ex;

  commit_entry_t   in2 [2];
  logic [1:0]      free2, ack2, we_gpr2, we_fpr2, lsu2;
  logic [4:0]      waddr2 [2];
  logic [XLEN-1:0] wdata2 [2];
  logic            amo_v2, commit_csr2, ff2, dom2, fence2, fencei2, sfence2, flush2;
  fu_op_e          csr_op2;
  logic [XLEN-1:0] csr_wdata2;
  exception_t      exc2;

  commit_entry_t   in4 [4];
  logic [2:0]      free4;
  logic [3:0]      ack4, we_gpr4, we_fpr4, lsu4;
  logic [4:0]      waddr4 [4];
  logic [XLEN-1:0] wdata4 [4];
  logic            amo_v4, commit_csr4, ff4, dom4, fence4, fencei4, sfence4, flush4;
  fu_op_e          csr_op4;
  logic [XLEN-1:0] csr_wdata4;
  exception_t      exc4;
`ifdef COMMIT_PERF_CNT_EN
  logic [63:0]     instret2, instret4;
  logic [31:0]     stall2, stall4;
`endif

  commit_stage_mp #(.NrCommitPorts(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .single_step_i(sstep),
    .commit_instr_i(in2), .commit_ack_o(ack2), .waddr_o(waddr2), .wdata_o(wdata2),
    .we_gpr_o(we_gpr2), .we_fpr_o(we_fpr2), .lsu_free_i(free2), .commit_lsu_o(lsu2),
    .no_st_pending_i(no_st), .amo_resp_i(amo_resp), .amo_valid_commit_o(amo_v2),
    .csr_op_o(csr_op2), .csr_wdata_o(csr_wdata2), .csr_rdata_i(csr_rdata),
    .csr_exception_i(csr_ex), .commit_csr_o(commit_csr2), .csr_write_fflags_o(ff2),
    .csr_write_dom_o(dom2), .fence_o(fence2), .fence_i_o(fencei2), .sfence_vma_o(sfence2),
    .flush_commit_o(flush2), .exception_o(exc2)
`ifdef COMMIT_PERF_CNT_EN
    , .instret_o(instret2), .stall_cnt_o(stall2)
`endif
  );

  commit_stage_mp #(.NrCommitPorts(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .single_step_i(sstep),
    .commit_instr_i(in4), .commit_ack_o(ack4), .waddr_o(waddr4), .wdata_o(wdata4),
    .we_gpr_o(we_gpr4), .we_fpr_o(we_fpr4), .lsu_free_i(free4), .commit_lsu_o(lsu4),
    .no_st_pending_i(no_st), .amo_resp_i(amo_resp), .amo_valid_commit_o(amo_v4),
    .csr_op_o(csr_op4), .csr_wdata_o(csr_wdata4), .csr_rdata_i(csr_rdata),
    .csr_exception_i(csr_ex), .commit_csr_o(commit_csr4), .csr_write_fflags_o(ff4),
    .csr_write_dom_o(dom4), .fence_o(fence4), .fence_i_o(fencei4), .sfence_vma_o(sfence4),
    .flush_commit_o(flush4), .exception_o(exc4)
`ifdef COMMIT_PERF_CNT_EN
    , .instret_o(instret4), .stall_cnt_o(stall4)
`endif
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int hold = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic commit_entry_t mk(op_class_e oc, fu_e fu, logic [4:0] rd, logic fpr,
                                       logic [XLEN-1:0] res);
    commit_entry_t e;
    e          = '0;
    e.valid    = 1'b1;
    e.op_class = oc;
    e.fu       = fu;
    e.rd       = rd;
    e.rd_fpr   = fpr;
    e.result   = res;
    return e;
  endfunction

  task automatic idle_inputs();
    foreach (in2[i]) in2[i] = '0;
    foreach (in4[i]) in4[i] = '0;
    halt = 1'b0; sstep = 1'b0; no_st = 1'b1;
    free2 = 2'd2; free4 = 3'd4;
    amo_resp = '0; csr_rdata = '0; csr_ex = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    in2[0] = mk(SIMPLE, FU_ALU, 5'd1, 1'b0, 64'h11);
    in2[1] = mk(SIMPLE, FU_ALU, 5'd2, 1'b0, 64'h22);
    tick();
    chk("rst_ack", ack2, 2'b00);
    chk("rst_fence", fence2, 1'b0);
    chk("rst_amo_v", amo_v2, 1'b0);

    rst = 1'b0; #1;
    chk("alu_ack", ack2, 2'b11);
    chk("alu_we_gpr", we_gpr2, 2'b11);
    chk("alu_we_fpr", we_fpr2, 2'b00);
    chk("alu_wdata1", wdata2[1], 64'h22);
    chk("alu_waddr1", waddr2[1], 5'd2);
`ifdef COMMIT_PERF_CNT_EN
    chk("perf_instret_rst", instret2, 64'd0);
    tick();
    chk("perf_instret_2", instret2, 64'd2);
`endif

    halt = 1'b1; #1;
    chk("halt_ack", ack2, 2'b00);
    halt = 1'b0; sstep = 1'b1; #1;
    chk("sstep_ack", ack2, 2'b01);
    sstep = 1'b0;
    in2[0].ex.valid = 1'b1; in2[0].ex.cause = 64'h5; #1;
    chk("ex0_ack", ack2, 2'b00);
    chk("ex0_valid", exc2.valid, 1'b1);
    chk("ex0_cause", exc2.cause, 64'h5);
    halt = 1'b1; #1;
    chk("ex0_halt_valid", exc2.valid, 1'b0);
    halt = 1'b0; in2[0].ex.valid = 1'b0; in2[1].ex.valid = 1'b1; #1;
    chk("ex1_ack", ack2, 2'b01);

    in2[0] = mk(SIMPLE, FU_FPU, 5'd3, 1'b1, 64'h0); in2[0].ex.cause = 64'h01;
    in2[1] = mk(SIMPLE, FU_FPU, 5'd4, 1'b1, 64'h0); in2[1].ex.cause = 64'h04; #1;
    chk("fpu_wdata", csr_wdata2, 64'h05);
    chk("fpu_ffw", ff2, 1'b1);
    chk("fpu_op", csr_op2, CSR_FFLAGS);
    chk("fpu_we_fpr", we_fpr2, 2'b11);
    chk("fpu_we_gpr", we_gpr2, 2'b00);
    sstep = 1'b1; #1;
    chk("fpu_sstep_wdata", csr_wdata2, 64'h01);
    sstep = 1'b0;

    in2[0] = mk(CSR, FU_CSR, 5'd4, 1'b0, 64'h99);
    in2[1] = mk(SIMPLE, FU_ALU, 5'd5, 1'b0, 64'h33);
    csr_rdata = 64'hBEEF; #1;
    chk("csr_ack", ack2, 2'b01);
    chk("csr_wdata0", wdata2[0], 64'hBEEF);
    chk("csr_commit", commit_csr2, 1'b1);
    chk("csr_op", csr_op2, CSR_RW);
    chk("csr_wdata", csr_wdata2, 64'h99);
    csr_ex.valid = 1'b1; csr_ex.cause = 64'h2; in2[0].ex.tval = 64'h55; #1;
    chk("csrex_ack", ack2, 2'b00);
    chk("csrex_valid", exc2.valid, 1'b1);
    chk("csrex_tval", exc2.tval, 64'h55);
    chk("csrex_commit", commit_csr2, 1'b0);
    csr_ex = '0;

    in2[0] = mk(CHG_DOM, FU_CSR, 5'd0, 1'b0, 64'h0); in2[0].dom = 2'd2; #1;
    chk("dom_ack", ack2, 2'b01);
    chk("dom_write", dom2, 1'b1);
    chk("dom_wdata", csr_wdata2, 64'h2);

    in2[0] = '0; in2[1] = '0;
    for (int i = 0; i < 3; i++) in4[i] = mk(STORE, FU_STORE, 5'd0, 1'b0, 64'h0);
    in4[3] = mk(SIMPLE, FU_ALU, 5'd7, 1'b0, 64'h44);
    free4 = 3'd2; #1;
    chk("st2_ack", ack4, 4'b0011);
    chk("st2_lsu", lsu4, 4'b0011);
    free4 = 3'd3; #1;
    chk("st3_ack", ack4, 4'b1111);
    chk("st3_lsu", lsu4, 4'b0111);
    free4 = 3'd0; #1;
    chk("st0_ack", ack4, 4'b0000);

    // FENCE with stores pending through cycle 3
    idle_inputs(); tick();
    in2[0] = mk(FENCE, FU_NONE, 5'd0, 1'b0, 64'h0);
    in2[1] = mk(SIMPLE, FU_ALU, 5'd1, 1'b0, 64'h1);
    no_st = 1'b0; #1;
    chk("fence_c1_ack", ack2, 2'b00);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 4) no_st = 1'b1;
      #1;
      if (c < 5) begin
        chk($sformatf("fence_c%0d_pulse", c), fence2, 1'b0);
        chk($sformatf("fence_c%0d_ack", c), ack2, 2'b00);
      end else begin
        chk("fence_c5_pulse", fence2, 1'b1);
        chk("fence_c5_ack", ack2, 2'b01);
        chk("fence_c5_fencei", fencei2, 1'b0);
      end
    end
    tick(); in2[0] = '0; in2[1] = '0; #1;
    chk("fence_after", fence2, 1'b0);

    // SFENCE drain aborted by halt, then retried
    in2[0] = mk(SFENCE, FU_NONE, 5'd0, 1'b0, 64'h0); no_st = 1'b0;
    tick(); halt = 1'b1; #1;
    chk("sf_halt_pulse", sfence2, 1'b0);
    tick(); halt = 1'b0; no_st = 1'b1; #1;
    chk("sf_idle_pulse", sfence2, 1'b0);
    tick(); #1;
    chk("sf_drain_pulse", sfence2, 1'b0);
    chk("sf_drain_ack", ack2, 2'b00);
    tick(); #1;
    chk("sf_issue_pulse", sfence2, 1'b1);
    chk("sf_issue_fence", fence2, 1'b0);
    chk("sf_issue_ack", ack2, 2'b01);
    tick(); in2[0] = '0; #1;

    // AMO: response 4 cycles later, halt raised mid-way
    in2[0] = mk(AMO, FU_LOAD, 5'd6, 1'b0, 64'h0);
    in2[1] = mk(SIMPLE, FU_ALU, 5'd1, 1'b0, 64'h1); #1;
    chk("amo_c0_valid", amo_v2, 1'b0);
    chk("amo_c0_ack", ack2, 2'b00);
    hold = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) halt = 1'b1;
      if (c == 4) begin amo_resp.ack = 1'b1; amo_resp.result = 64'hABCD; end
      #1;
      if (amo_v2) hold++;
      if (c < 4) chk($sformatf("amo_c%0d_ack", c), ack2, 2'b00);
    end
    chk("amo_ack", ack2, 2'b01);
    chk("amo_we_gpr", we_gpr2, 2'b01);
    chk("amo_wdata0", wdata2[0], 64'hABCD);
    chk("amo_flush", flush2, 1'b1);
    chk("amo_hold_cycles", hold, 4);
    tick(); amo_resp = '0; halt = 1'b0; in2[0] = '0; in2[1] = '0; #1;
    chk("amo_after_valid", amo_v2, 1'b0);
    chk("amo_after_flush", flush2, 1'b0);

    // Reset while draining
    in2[0] = mk(FENCE, FU_NONE, 5'd0, 1'b0, 64'h0); no_st = 1'b0;
    tick(); tick();
    rst = 1'b1; #1;
    chk("rstd_ack", ack2, 2'b00);
    chk("rstd_fence", fence2, 1'b0);
    tick(); rst = 1'b0;
    in2[0] = mk(SIMPLE, FU_ALU, 5'd1, 1'b0, 64'h1);
    in2[1] = mk(SIMPLE, FU_ALU, 5'd2, 1'b0, 64'h2); #1;
    chk("rstd_idle_ack", ack2, 2'b11);
    chk("rstd_amo_v", amo_v2, 1'b0);
    chk("rstd_fence_after", fence2, 1'b0);
`ifdef COMMIT_PERF_CNT_EN
    chk("rstd_instret", instret2, 64'd0);
    chk("rstd_stall", stall2, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
